// File: rtl/next_state_sequencer_pkg.sv
// Shared control encodings, state constants and the instruction-to-state table.
package next_state_sequencer_pkg;

  localparam int unsigned STATE_W  = 7;
  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned FUNCT_W  = 6;

  typedef enum logic [2:0] {
    NS_ENCODE = 3'd0,
    NS_FETCH  = 3'd1,
    NS_JUMP   = 3'd2,
    NS_INC    = 3'd3,
    NS_CJUMP  = 3'd4,
    NS_CENC   = 3'd5,
    NS_WAIT   = 3'd6,
    NS_HALT   = 3'd7
  } ns_ctl_e;

  typedef enum logic [1:0] {
    CS_MOC   = 2'd0,
    CS_COND  = 2'd1,
    CS_ONE   = 2'd2,
    CS_ZERO  = 2'd3
  } cond_sel_e;

  localparam logic [STATE_W-1:0] RESET_ST = 7'd0;
  localparam logic [STATE_W-1:0] FETCH_ST = 7'd1;
  localparam logic [STATE_W-1:0] HALT_ST  = 7'd5;

  // Instruction decode table: maps opcode/funct to the first execute state.
  function automatic logic [STATE_W-1:0] encode_state(
    input logic [OPCODE_W-1:0] opcode,
    input logic [FUNCT_W-1:0]  funct
  );
    logic [STATE_W-1:0] st;
    st = HALT_ST;
    case (opcode)
      6'h00: begin
        if (funct == 6'h21)      st = 7'd6;
        else if (funct == 6'h23) st = 7'd16;
        else                     st = HALT_ST;
      end
      6'h23:   st = 7'd7;
      6'h2B:   st = 7'd10;
      6'h04:   st = 7'd31;
      6'h0F:   st = 7'd30;
      default: st = HALT_ST;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/next_state_sequencer_instr_state_encoder.sv
// Combinational instruction encoder: opcode/funct to dispatch state.
module instr_state_encoder
  import next_state_sequencer_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [6:0] enc_state
);

  // Table lookup lives in the package so it has a single definition.
  always_comb begin
    enc_state = encode_state(opcode, funct);
  end

endmodule

// File: rtl/next_state_sequencer.sv
// Microprogram next-state sequencer with WAIT handshake and sticky timeout.
module next_state_sequencer
  import next_state_sequencer_pkg::*;
#(
  parameter int unsigned NUM_STATES = 37,
  parameter int unsigned WAIT_LIMIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic [2:0] ns_ctl,
  input  logic [1:0] cond_sel,
  input  logic       inv,
  input  logic [6:0] cr_addr,
  input  logic       moc,
  input  logic       cond,
  output logic [6:0] current_state,
  output logic       wait_active,
  output logic       timeout
);

  localparam int unsigned CNT_W = 5;

  logic [STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic               timeout_q, timeout_d;
  logic [STATE_W-1:0] enc_state;
  logic [STATE_W-1:0] state_inc;
  logic [STATE_W-1:0] sel_state;
  logic               sel_cond;
  logic               s_cond;
  logic               wait_hit;

  instr_state_encoder u_encoder (
    .opcode    (opcode),
    .funct     (funct),
    .enc_state (enc_state)
  );

  // Condition select and polarity.
  always_comb begin
    sel_cond = 1'b0;
    case (cond_selhelper(cond_sel))
      CS_MOC:  sel_cond = moc;
      CS_COND: sel_cond = cond;
      CS_ONE:  sel_cond = 1'b1;
      CS_ZERO: sel_cond = 1'b0;
      default: sel_cond = 1'b0;
    endcase
    s_cond      = sel_cond ^ inv;
    wait_active = (ns_ctl == NS_WAIT) && !s_cond;
  end

  function automatic cond_sel_e cond_selhelper(input logic [1:0] v);
    return cond_sel_e'(v);
  endfunction

  // Next-state selection, wait timeout and range clamp.
  always_comb begin
    state_inc  = state_q + 7'd1;
    sel_state  = RESET_ST;
    wait_cnt_d = '0;
    timeout_d  = timeout_q;
    wait_hit   = 1'b0;

    case (ns_ctl_e'(ns_ctl))
      NS_ENCODE: sel_state = enc_state;
      NS_FETCH:  sel_state = FETCH_ST;
      NS_JUMP:   sel_state = cr_addr;
      NS_INC:    sel_state = state_inc;
      NS_CJUMP:  sel_state = s_cond ? cr_addr : state_inc;
      NS_CENC:   sel_state = s_cond ? enc_state : state_inc;
      NS_WAIT:   sel_state = s_cond ? state_inc : state_q;
      NS_HALT:   sel_state = RESET_ST;
      default:   sel_state = RESET_ST;
    endcase

    // The limit-th consecutive unsatisfied cycle diverts to the halt state.
    if (wait_active) begin
      if (wait_cnt_q == CNT_W'(WAIT_LIMIT - 1)) begin
        wait_hit   = 1'b1;
        wait_cnt_d = '0;
        timeout_d  = 1'b1;
      end else begin
        wait_cnt_d = wait_cnt_q + 5'd1;
      end
    end

    if (wait_hit) begin
      sel_state = HALT_ST;
    end

    state_d = (32'(sel_state) >= NUM_STATES) ? RESET_ST : sel_state;
  end

  // State, wait counter and sticky timeout registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RESET_ST;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign current_state = state_q;
  assign timeout       = timeout_q;

endmodule

// File: tb/tb_next_state_sequencer.sv
// Directed-vector bench for next_state_sequencer.
module tb_next_state_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic [2:0] ns_ctl;
  logic [1:0] cond_sel;
  logic       inv;
  logic [6:0] cr_addr;
  logic       moc;
  logic       cond;
  logic [6:0] current_state;
  logic       wait_active;
  logic       timeout;

  int errors = 0;
  int checks = 0;

  next_state_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .opcode        (opcode),
    .funct         (funct),
    .ns_ctl        (ns_ctl),
    .cond_sel      (cond_sel),
    .inv           (inv),
    .cr_addr       (cr_addr),
    .moc           (moc),
    .cond          (cond),
    .current_state (current_state),
    .wait_active   (wait_active),
    .timeout       (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply one control word and clock it in.
  task automatic step(input logic [2:0] ns, input logic [6:0] cr);
    ns_ctl  = ns;
    cr_addr = cr;
    tick();
  endtask

  task automatic goto_state(input logic [6:0] st);
    step(3'd2, st);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    opcode   = 6'(($urandom));
    funct    = 6'(($urandom));
    ns_ctl   = 3'(($urandom));
    cond_sel = 2'(($urandom));
    inv      = 1'($urandom);
    cr_addr  = 7'(($urandom));
    moc      = 1'($urandom);
    cond     = 1'($urandom);
    tick();
    ns_ctl  = 3'(($urandom));
    cr_addr = 7'(($urandom));
    tick();
    check("reset_state", 32'(current_state), 32'd0);
    check("reset_timeout", 32'(timeout), 32'd0);
    reset    = 1'b0;
    inv      = 1'b0;
    moc      = 1'b0;
    cond     = 1'b0;
    cond_sel = 2'd2;
    funct    = 6'h00;

    step(3'd1, 7'd0);
    check("fetch", 32'(current_state), 32'd1);

    // Encoder table
    opcode = 6'h23; step(3'd0, 7'd0); check("enc_lw", 32'(current_state), 32'd7);
    opcode = 6'h3F; step(3'd0, 7'd0); check("enc_bad", 32'(current_state), 32'd5);
    opcode = 6'h00; funct = 6'h21; step(3'd0, 7'd0); check("enc_addu", 32'(current_state), 32'd6);
    funct = 6'h23; step(3'd0, 7'd0); check("enc_subu", 32'(current_state), 32'd16);
    funct = 6'h00; step(3'd0, 7'd0); check("enc_rbad", 32'(current_state), 32'd5);
    opcode = 6'h2B; step(3'd0, 7'd0); check("enc_sw", 32'(current_state), 32'd10);
    opcode = 6'h0F; step(3'd0, 7'd0); check("enc_lui", 32'(current_state), 32'd30);
    opcode = 6'h04; step(3'd0, 7'd0); check("enc_beq", 32'(current_state), 32'd31);

    // Conditional jump from 31
    cond_sel = 2'd1; cond = 1'b1; inv = 1'b0;
    step(3'd4, 7'd33); check("cjump_taken", 32'(current_state), 32'd33);
    step(3'd0, 7'd0);  check("back_to_31", 32'(current_state), 32'd31);
    inv = 1'b1;
    step(3'd4, 7'd33); check("cjump_inv", 32'(current_state), 32'd32);
    inv = 1'b0;

    // Conditional encode
    cond_sel = 2'd3; opcode = 6'h23;
    step(3'd5, 7'd0); check("cenc_false", 32'(current_state), 32'd33);
    cond_sel = 2'd2;
    step(3'd5, 7'd0); check("cenc_true", 32'(current_state), 32'd7);

    // WAIT handshake: three unsatisfied cycles, then moc completes
    cond_sel = 2'd0; moc = 1'b0; ns_ctl = 3'd6;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("wait_active_hi", 32'(wait_active), 32'd1);
      tick();
      check("wait_hold", 32'(current_state), 32'd7);
    end
    moc = 1'b1;
    #1;
    check("wait_active_lo", 32'(wait_active), 32'd0);
    tick();
    check("wait_done", 32'(current_state), 32'd8);
    check("wait_no_to", 32'(timeout), 32'd0);

    // Timeout after 16 unsatisfied cycles
    opcode = 6'h23; step(3'd0, 7'd0);
    moc = 1'b0; ns_ctl = 3'd6;
    for (int i = 0; i < 15; i++) tick();
    check("to_pre_state", 32'(current_state), 32'd7);
    check("to_pre_flag", 32'(timeout), 32'd0);
    tick();
    check("to_state", 32'(current_state), 32'd5);
    check("to_flag", 32'(timeout), 32'd1);
    moc = 1'b1;
    step(3'd3, 7'd0);
    check("to_sticky_state", 32'(current_state), 32'd6);
    check("to_sticky_flag", 32'(timeout), 32'd1);

    // Condition arriving on the limit cycle advances normally
    do_reset();
    check("rst2_flag", 32'(timeout), 32'd0);
    opcode = 6'h23; step(3'd0, 7'd0);
    moc = 1'b0; ns_ctl = 3'd6;
    for (int i = 0; i < 15; i++) tick();
    moc = 1'b1;
    tick();
    check("limit_race_state", 32'(current_state), 32'd8);
    check("limit_race_flag", 32'(timeout), 32'd0);

    // Reset mid-WAIT clears the counter
    step(3'd0, 7'd0);
    moc = 1'b0; ns_ctl = 3'd6;
    for (int i = 0; i < 10; i++) tick();
    ns_ctl = 3'd1;
    do_reset();
    check("rst_mid_state", 32'(current_state), 32'd0);
    step(3'd0, 7'd0);
    check("post_rst_enc", 32'(current_state), 32'd7);
    ns_ctl = 3'd6;
    for (int i = 0; i < 15; i++) tick();
    check("cnt_cleared", 32'(timeout), 32'd0);
    tick();
    check("cnt_cleared_to", 32'(current_state), 32'd5);
    moc = 1'b1;

    // Range clamp and wrap
    step(3'd2, 7'd36); check("jump36", 32'(current_state), 32'd36);
    step(3'd3, 7'd0);  check("inc_clamp", 32'(current_state), 32'd0);
    step(3'd2, 7'd100); check("jump_clamp", 32'(current_state), 32'd0);
    goto_state(7'd30);
    step(3'd7, 7'd0);  check("halt", 32'(current_state), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/next_state_sequencer.md
NEXT_STATE_SEQUENCER -- requirements
Module: next_state_sequencer

Interface
REQ-001 SHALL have parameter NUM_STATES, default 37, meaning count of valid control states (0..NUM_STATES-1).
REQ-002 SHALL have parameter WAIT_LIMIT, default 16, meaning maximum number of consecutive unsatisfied WAIT cycles before timeout.
REQ-003 SHALL have port clk, input, 1, rising-edge clock.
REQ-004 SHALL have port reset, input, 1, reset, synchronous, active-high.
REQ-005 SHALL have port opcode, input, 6, instruction opcode field from the instruction register.
REQ-006 SHALL have port funct, input, 6, instruction function field, used when opcode = 6'h00.
REQ-007 SHALL have port ns_ctl, input, 3, next-state control field of the current control word.
REQ-008 SHALL have port cond_sel, input, 2, condition source: 0 = moc, 1 = cond, 2 = constant 1, 3 = constant 0.
REQ-009 SHALL have port inv, input, 1, inverts the selected condition.
REQ-010 SHALL have port cr_addr, input, 7, jump target field of the current control word.
REQ-011 SHALL have port moc, input, 1, memory-operation-complete from the memory interface.
REQ-012 SHALL have port cond, input, 1, branch/ALU condition flag.
REQ-013 SHALL have port current_state, output, 7, registered state driven to the control-word ROM.
REQ-014 SHALL have port wait_active, output, 1, high while a WAIT is unsatisfied.
REQ-015 SHALL have port timeout, output, 1, sticky WAIT-timeout flag.

Function
REQ-016 SHALL compute S = selected condition XOR inv, combinationally.
REQ-017 SHALL select next state by ns_ctl as follows: 0 ENCODE = encoder output; 1 FETCH = 7'd1; 2 JUMP = cr_addr; 3 INC = current_state+1; 4 CJUMP = S ? cr_addr : current_state+1; 5 CENC = S ? encoder output : current_state+1; 6 WAIT = S ? current_state+1 : current_state; 7 HALT = 7'd0.
REQ-018 SHALL register the selected next state on every rising clk, giving a latency of exactly one cycle from control word to new current_state.
REQ-019 SHALL compute current_state+1 modulo 128.
REQ-020 SHALL force 7'd0 for any selected next state >= NUM_STATES.
REQ-021 SHALL implement the encoder table: opcode 6'h00/funct 6'h21 -> 7'd6; opcode 6'h00/funct 6'h23 -> 7'd16; opcode 6'h23 -> 7'd7; opcode 6'h2B -> 7'd10; opcode 6'h04 -> 7'd31; opcode 6'h0F -> 7'd30; every unlisted code -> 7'd5 (halt state).
REQ-022 SHALL drive wait_active = (ns_ctl == 6) AND NOT S, combinationally.
REQ-023 SHALL count consecutive cycles with wait_active high in a 5-bit counter, cleared in any cycle where wait_active is low.
REQ-024 SHALL, in the WAIT_LIMIT-th consecutive unsatisfied cycle, load next state 7'd5, set timeout, and clear the counter.
REQ-025 SHALL, if S rises in the same cycle as the limit, advance normally (current_state+1) without setting timeout.
REQ-026 SHALL hold timeout high until reset; timeout SHALL NOT alter any other sequencing.

Reset
REQ-027 SHALL have reset take priority over all other inputs.
REQ-028 SHALL, on reset, set current_state = 7'd0, the wait counter = 0 and timeout = 0, with wait_active following its combinational definition.
REQ-029 SHALL, on reset asserted mid-WAIT or mid-instruction, abandon the operation; the first post-reset edge with reset low SHALL sequence from state 0.

Structure
REQ-030 SHALL place the ns_ctl encodings, cond_sel encodings, the state constants (FETCH=1, HALT_ST=5, RESET_ST=0) and the encoder table in a shared package, e.g. control_pkg.
REQ-031 SHALL implement the encoder as the combinational sub-module instr_state_encoder (opcode, funct -> 7-bit state).

Verification
REQ-032 SHALL verify reset: reset high for 2 cycles with random inputs -> current_state=0, timeout=0.
REQ-033 SHALL verify the ENCODE path: ns_ctl=0, opcode=6'h23 -> current_state=7 next cycle; opcode=6'h3F -> 5.
REQ-034 SHALL verify CJUMP: state 31, ns_ctl=4, cond_sel=1, cond=1, inv=0, cr_addr=33 -> 33; same with inv=1 -> 32.
REQ-035 SHALL verify the WAIT handshake: state 7, ns_ctl=6, cond_sel=0, moc low 3 cycles then high -> state holds 7 for 3 cycles with wait_active=1, then 8.
REQ-036 SHALL verify timeout: moc held low -> on the 16th wait cycle the next state is 5 and timeout=1; then moc rising on exactly cycle 16 (retest after reset) -> state 8, timeout=0.
REQ-037 SHALL verify range/wrap: state 36, ns_ctl=3 -> 0; ns_ctl=2, cr_addr=100 -> 0.
